// File: rtl/aes128_enc_iter_ctrl_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the iterative AES-128 encryptor.
package aes128_enc_iter_ctrl_pkg;

   localparam logic [3:0] AES_NUM_ROUNDS = 4'd10;
   localparam logic [7:0] AES_RCON_INIT  = 8'h01;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse computed as x^254 (zero maps to zero), followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes128_enc_iter_ctrl_if.sv
// Host request / response bundle for the iterative AES-128 encryptor.
interface aes128_enc_iter_ctrl_if;
   logic         start;
   logic [127:0] data_in;
   logic [127:0] key_in;
   logic         in_ready;
   logic         busy;
   logic         valid;
   logic [127:0] data_out;

   modport master (output start, data_in, key_in,
                   input  in_ready, busy, valid, data_out);
   modport slave  (input  start, data_in, key_in,
                   output in_ready, busy, valid, data_out);
endinterface

// File: rtl/aes128_enc_iter_ctrl_round.sv
// One combinational AES encrypt round: SubBytes, ShiftRows, MixColumns (skipped on last), AddRoundKey.
module aes128_enc_iter_ctrl_round
   import aes128_enc_iter_ctrl_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] round_key_i,
   input  logic         last_round_i,
   output logic [127:0] state_o
);

   logic [127:0] sub_s;
   logic [127:0] shift_s;
   logic [127:0] mix_s;

   // Byte n of the state sits at [127-8n -: 8]; n = 4*column + row.
   for (genvar gi = 0; gi < 16; gi++) begin : g_sub
      assign sub_s[127-8*gi -: 8] = sbox(state_i[127-8*gi -: 8]);
   end

   for (genvar gc = 0; gc < 4; gc++) begin : g_col
      for (genvar gr = 0; gr < 4; gr++) begin : g_row
         assign shift_s[127-8*(4*gc+gr) -: 8] = sub_s[127-8*(4*((gc+gr)%4)+gr) -: 8];
      end
      assign mix_s[127-32*gc -: 32] = mix_column(shift_s[127-32*gc -: 32]);
   end

   assign state_o = (last_round_i ? shift_s : mix_s) ^ round_key_i;

endmodule

// File: rtl/aes128_enc_iter_ctrl.sv
// Iterative AES-128 encryption sequencer: initial AddRoundKey, then ten one-cycle rounds with on-the-fly key expansion.
module aes128_enc_iter_ctrl
   import aes128_enc_iter_ctrl_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   aes128_enc_iter_ctrl_if.slave  bus
);

   state_e       state_q, state_d;
   logic [127:0] state_reg_q, state_reg_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   round_q, round_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] data_out_q, data_out_d;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  nw0, nw1, nw2, nw3;
   logic [127:0] next_key;
   logic [127:0] round_out;
   logic         last_round;

   assign {w0, w1, w2, w3} = key_q;
   assign nw0      = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
   assign nw1      = w1 ^ nw0;
   assign nw2      = w2 ^ nw1;
   assign nw3      = w3 ^ nw2;
   assign next_key = {nw0, nw1, nw2, nw3};

   assign last_round = (round_q == AES_NUM_ROUNDS);

   aes128_enc_iter_ctrl_round u_round (
      .state_i      (state_reg_q),
      .round_key_i  (next_key),
      .last_round_i (last_round),
      .state_o      (round_out)
   );

   always_comb begin
      state_d     = state_q;
      state_reg_d = state_reg_q;
      key_d       = key_q;
      round_d     = round_q;
      rcon_d      = rcon_q;
      data_out_d  = data_out_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_reg_d = bus.data_in ^ bus.key_in;
               key_d       = bus.key_in;
               round_d     = 4'd1;
               rcon_d      = AES_RCON_INIT;
               state_d     = S_ROUND;
            end
         end
         S_ROUND: begin
            // Counter values outside 1..10 cannot occur in normal operation; bail out to IDLE.
            if (round_q == 4'd0 || round_q > AES_NUM_ROUNDS) begin
               state_d = S_IDLE;
            end else begin
               state_reg_d = round_out;
               key_d       = next_key;
               rcon_d      = xtime(rcon_q);
               if (last_round) begin
                  data_out_d = round_out;
                  state_d    = S_DONE;
               end else begin
                  round_d = round_q + 4'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         state_reg_q <= '0;
         key_q       <= '0;
         round_q     <= 4'd0;
         rcon_q      <= AES_RCON_INIT;
         data_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         state_reg_q <= state_reg_d;
         key_q       <= key_d;
         round_q     <= round_d;
         rcon_q      <= rcon_d;
         data_out_q  <= data_out_d;
      end
   end

   assign bus.in_ready = (state_q == S_IDLE);
   assign bus.busy     = (state_q == S_ROUND) || (state_q == S_DONE);
   assign bus.valid    = (state_q == S_DONE);
   assign bus.data_out = data_out_q;

endmodule
